// File: rtl/ipsa_out_pkg.sv
// Shared defaults, FSM state encoding and saturating-counter helper for the
// IPSA output packer.
package ipsa_out_pkg;

    localparam int DATA_W        = 1024;
    localparam int KEEP_W        = DATA_W / 8;
    localparam int DEPTH         = 16;
    localparam int MAX_PKT_BEATS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCEPT  = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/ipsa_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; the head entry
// is visible on rd_data whenever count is non-zero.
module ipsa_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_wr_s;
    logic             do_rd_s;

    // Writes and pops are masked against full/empty so the pointers can never run past each other.
    assign do_wr_s = wr_en && (count_r != CNT_W'(DEPTH));
    assign do_rd_s = rd_en && (count_r != {CNT_W{1'b0}});
    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage array; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ipsa_out_packer.sv
// Converts the IPSA pipeline's valid-only beat stream into AXI-Stream packets,
// reserving FIFO space per packet so the non-stallable source never overflows.
module ipsa_out_packer #(
    parameter int DATA_W        = ipsa_out_pkg::DATA_W,
    parameter int DEPTH         = ipsa_out_pkg::DEPTH,
    parameter int MAX_PKT_BEATS = ipsa_out_pkg::MAX_PKT_BEATS
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ipsa_io_en_out,
    input  logic [DATA_W-1:0]     ipsa_io_data_out,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [31:0]           drop_pkt_cnt,
    output logic [31:0]           trunc_pkt_cnt
);

    import ipsa_out_pkg::*;

    localparam int KEEP_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int BC_W   = $clog2(MAX_PKT_BEATS + 1);

    state_e            state_r, state_n;
    logic [DATA_W-1:0] hold_data_r, hold_data_n;
    logic              hold_valid_r, hold_valid_n;
    logic [BC_W-1:0]   beat_cnt_r, beat_cnt_n;
    logic [31:0]       drop_cnt_r, trunc_cnt_r;
    logic              fifo_wr_s, fifo_last_s, fifo_rd_s;
    logic              drop_inc_s, trunc_inc_s, admit_s, tvalid_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [DATA_W:0]   fifo_head_s;

    // A packet is admitted only if a worst-case (MAX_PKT_BEATS) packet fits; pops during the packet only add room.
    assign admit_s = (CNT_W'(DEPTH) - fifo_count_s) >= CNT_W'(MAX_PKT_BEATS);

    // Packet admission / truncation FSM; the hold stage delays each beat so tlast is known at write time.
    always_comb begin
        state_n      = state_r;
        hold_data_n  = hold_data_r;
        hold_valid_n = hold_valid_r;
        beat_cnt_n   = beat_cnt_r;
        fifo_wr_s    = 1'b0;
        fifo_last_s  = 1'b0;
        drop_inc_s   = 1'b0;
        trunc_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ipsa_io_en_out && admit_s) begin
                    hold_data_n  = ipsa_io_data_out;
                    hold_valid_n = 1'b1;
                    beat_cnt_n   = BC_W'(1);
                    state_n      = ST_ACCEPT;
                end else if (ipsa_io_en_out) begin
                    drop_inc_s = 1'b1;
                    state_n    = ST_DISCARD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                fifo_wr_s = hold_valid_r;
                if (ipsa_io_en_out && (beat_cnt_r < BC_W'(MAX_PKT_BEATS))) begin
                    fifo_last_s = 1'b0;
                    hold_data_n = ipsa_io_data_out;
                    beat_cnt_n  = beat_cnt_r + BC_W'(1);
                end else if (ipsa_io_en_out) begin
                    fifo_last_s  = 1'b1;
                    hold_valid_n = 1'b0;
                    trunc_inc_s  = 1'b1;
                    state_n      = ST_DISCARD;
                end else begin
                    fifo_last_s  = 1'b1;
                    hold_valid_n = 1'b0;
                    state_n      = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (ipsa_io_en_out) begin
                    state_n = ST_DISCARD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                hold_valid_n = 1'b0;
                state_n      = ST_IDLE;
            end
        endcase
    end

    // FSM, hold stage and saturating drop/truncate counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r      <= ST_IDLE;
            hold_data_r  <= {DATA_W{1'b0}};
            hold_valid_r <= 1'b0;
            beat_cnt_r   <= {BC_W{1'b0}};
            drop_cnt_r   <= 32'd0;
            trunc_cnt_r  <= 32'd0;
        end else begin
            state_r      <= state_n;
            hold_data_r  <= hold_data_n;
            hold_valid_r <= hold_valid_n;
            beat_cnt_r   <= beat_cnt_n;
            drop_cnt_r   <= drop_inc_s  ? sat_inc(drop_cnt_r)  : drop_cnt_r;
            trunc_cnt_r  <= trunc_inc_s ? sat_inc(trunc_cnt_r) : trunc_cnt_r;
        end
    end

    ipsa_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .wr_en   (fifo_wr_s),
        .wr_data ({fifo_last_s, hold_data_r}),
        .rd_en   (fifo_rd_s),
        .rd_data (fifo_head_s),
        .count   (fifo_count_s)
    );

    // Head fields are masked while empty so stale storage never leaks out after reset.
    assign tvalid_s      = (fifo_count_s != {CNT_W{1'b0}});
    assign fifo_rd_s     = tvalid_s && m_axis_tready;
    assign m_axis_tvalid = tvalid_s;
    assign m_axis_tdata  = tvalid_s ? fifo_head_s[DATA_W-1:0] : {DATA_W{1'b0}};
    assign m_axis_tlast  = tvalid_s && fifo_head_s[DATA_W];
    assign m_axis_tkeep  = tvalid_s ? {KEEP_W{1'b1}} : {KEEP_W{1'b0}};
    assign drop_pkt_cnt  = drop_cnt_r;
    assign trunc_pkt_cnt = trunc_cnt_r;

endmodule

// File: tb/tb_ipsa_out_packer.sv
// Directed bench for ipsa_out_packer: hand-built expected beat lists drained
// through a per-cycle AXI-Stream monitor.
module tb_ipsa_out_packer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          tvalid;
    logic          tready = 1'b0;
    logic [DW-1:0] tdata;
    logic [3:0]    tkeep;
    logic          tlast;
    logic [31:0]   drop_cnt;
    logic [31:0]   trunc_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_no   = 0;
    int rx_cnt   = 0;
    int v_cycles = 0;
    int first_v  = -1;
    int t_start  = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    logic [DW:0]   exp_q[$];

    always #5 clk = ~clk;

    ipsa_out_packer #(
        .DATA_W        (DW),
        .DEPTH         (16),
        .MAX_PKT_BEATS (4)
    ) dut (
        .ap_clk           (clk),
        .ap_rst_n         (rst_n),
        .ipsa_io_en_out   (en_in),
        .ipsa_io_data_out (data_in),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready),
        .m_axis_tdata     (tdata),
        .m_axis_tkeep     (tkeep),
        .m_axis_tlast     (tlast),
        .drop_pkt_cnt     (drop_cnt),
        .trunc_pkt_cnt    (trunc_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    // One clock cycle: apply inputs at the falling edge, monitor outputs, wait for next falling edge.
    task automatic cyc(input logic en, input logic [DW-1:0] d, input logic rdy);
        logic [DW:0] e;
        en_in   = en;
        data_in = d;
        tready  = rdy;
        #1;
        if (tvalid) begin
            check("tkeep_on", 64'(tkeep), 64'hF);
            v_cycles++;
            if (first_v < 0) first_v = cyc_no;
            if (prev_stall) begin
                check("stall_tdata", 64'(tdata), 64'(prev_data));
                check("stall_tlast", 64'(tlast), 64'(prev_last));
            end
            if (rdy) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(tdata), 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", 64'(tdata), 64'(e[DW-1:0]));
                    check("tlast", 64'(tlast), 64'(e[DW]));
                end
            end
        end else begin
            check("tkeep_off", 64'(tkeep), 64'h0);
            check("tlast_idle", 64'(tlast), 64'h0);
        end
        prev_stall = tvalid && !rdy;
        prev_data  = tdata;
        prev_last  = tlast;
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, rdy);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        check("rst_tvalid", 64'(tvalid), 64'h0);
        check("rst_tkeep", 64'(tkeep), 64'h0);
        check("rst_tlast", 64'(tlast), 64'h0);
        check("rst_drop", 64'(drop_cnt), 64'h0);
        check("rst_trunc", 64'(trunc_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Single beat: visible two cycles after acceptance, for exactly one cycle
        exp_q.push_back({1'b1, 32'hA5A5_0001});
        rx_cnt = 0; v_cycles = 0; first_v = -1; t_start = cyc_no;
        cyc(1'b1, 32'hA5A5_0001, 1'b1);
        idle(6, 1'b1);
        check("single_latency", 64'(first_v - t_start), 64'd2);
        check("single_vcycles", 64'(v_cycles), 64'd1);
        check("single_rx", 64'(rx_cnt), 64'd1);

        // Three-beat packet, tlast only on the final beat
        exp_q.push_back({1'b0, 32'h0000_000A});
        exp_q.push_back({1'b0, 32'h0000_000B});
        exp_q.push_back({1'b1, 32'h0000_000C});
        rx_cnt = 0;
        cyc(1'b1, 32'h0000_000A, 1'b1);
        cyc(1'b1, 32'h0000_000B, 1'b1);
        cyc(1'b1, 32'h0000_000C, 1'b1);
        idle(6, 1'b1);
        check("p3_rx", 64'(rx_cnt), 64'd3);
        check("p3_drop", 64'(drop_cnt), 64'h0);
        check("p3_trunc", 64'(trunc_cnt), 64'h0);

        // Six-beat packet truncated to four
        for (int b = 0; b < 4; b++) exp_q.push_back({(b == 3), 32'hD000_0001 + 32'(b)});
        rx_cnt = 0;
        for (int b = 0; b < 6; b++) cyc(1'b1, 32'hD000_0001 + 32'(b), 1'b1);
        idle(8, 1'b1);
        check("trunc_rx", 64'(rx_cnt), 64'd4);
        check("trunc_cnt", 64'(trunc_cnt), 64'd1);
        check("trunc_drop", 64'(drop_cnt), 64'h0);

        // Fill all 16 entries with tready low, fifth packet must be dropped
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back({(b == 3), 32'h4000_0000 + 32'(p * 16 + b)});
                cyc(1'b1, 32'h4000_0000 + 32'(p * 16 + b), 1'b0);
            end
            cyc(1'b0, '0, 1'b0);
        end
        for (int b = 0; b < 3; b++) cyc(1'b1, 32'h5555_0000 + 32'(b), 1'b0);
        idle(3, 1'b0);
        check("full_drop", 64'(drop_cnt), 64'd1);
        check("full_trunc", 64'(trunc_cnt), 64'd1);
        rx_cnt = 0;
        idle(24, 1'b1);
        check("full_rx", 64'(rx_cnt), 64'd16);
        check("full_left", 64'(exp_q.size()), 64'd0);

        // Reset during beat 2 of a 3-beat packet with 5 beats queued
        for (int b = 0; b < 4; b++) cyc(1'b1, 32'h7000_0000 + 32'(b), 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b1, 32'h7100_0000, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b1, 32'h7200_0001, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        rx_cnt = 0;
        cyc(1'b1, 32'h7200_0002, 1'b1);
        check("mid_rst_tvalid", 64'(tvalid), 64'h0);
        check("mid_rst_drop", 64'(drop_cnt), 64'h0);
        check("mid_rst_trunc", 64'(trunc_cnt), 64'h0);
        rst_n = 1'b1;
        exp_q.push_back({1'b1, 32'h7200_0003});
        cyc(1'b1, 32'h7200_0003, 1'b1);
        cyc(1'b0, '0, 1'b1);
        exp_q.push_back({1'b0, 32'h7300_0001});
        exp_q.push_back({1'b1, 32'h7300_0002});
        cyc(1'b1, 32'h7300_0001, 1'b1);
        cyc(1'b1, 32'h7300_0002, 1'b1);
        idle(6, 1'b1);
        check("post_rst_rx", 64'(rx_cnt), 64'd3);
        check("post_rst_left", 64'(exp_q.size()), 64'd0);

        // Twenty single-beat packets with tready toggling every cycle
        rx_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back({1'b1, 32'h6000_0000 + 32'(i)});
            cyc(1'b1, 32'h6000_0000 + 32'(i), cyc_no[0]);
            cyc(1'b0, '0, cyc_no[0]);
        end
        for (int i = 0; i < 30; i++) cyc(1'b0, '0, cyc_no[0]);
        check("toggle_rx", 64'(rx_cnt), 64'd20);
        check("toggle_left", 64'(exp_q.size()), 64'd0);
        check("toggle_drop", 64'(drop_cnt), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
